// File: rtl/pc_unit.sv
`default_nettype none
// ============================================================================
// Module      : pc_unit
// Description : Fetch-stage program counter with stall, branch load and a
//               circular return-address stack for call/return.
// Revision    : 1.0 - initial release
// ============================================================================

module pc_unit #(
    parameter int unsigned                ADDR_WIDTH = 64,
    parameter int unsigned                INC        = 4,
    parameter logic [ADDR_WIDTH-1:0]      RESET_VEC  = '0,
    parameter int unsigned                RAS_DEPTH  = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  stall,
    input  logic                  branch_taken,
    input  logic [ADDR_WIDTH-1:0] branch_target,
    input  logic                  call,
    input  logic                  ret,
    output logic [ADDR_WIDTH-1:0] pc_out,
    output logic [ADDR_WIDTH-1:0] adder_out,
    output logic                  ras_empty,
    output logic                  ras_full,
    output logic                  ras_overflow,
    output logic                  ras_underflow
);

    localparam int unsigned c_PTR_W = (RAS_DEPTH > 1) ? $clog2(RAS_DEPTH) : 1;
    localparam int unsigned c_CNT_W = $clog2(RAS_DEPTH + 1);

    localparam logic [c_CNT_W-1:0]    c_CNT_FULL = c_CNT_W'(RAS_DEPTH);
    localparam logic [c_CNT_W-1:0]    c_CNT_ONE  = c_CNT_W'(1);
    localparam logic [c_PTR_W-1:0]    c_PTR_ONE  = c_PTR_W'(1);
    localparam logic [ADDR_WIDTH-1:0] c_INC      = ADDR_WIDTH'(INC);

    // Architectural state
    logic [ADDR_WIDTH-1:0] pc_q,  pc_d;
    logic [c_CNT_W-1:0]    cnt_q, cnt_d;
    logic [c_PTR_W-1:0]    ptr_q, ptr_d;
    logic                  ovf_q, ovf_d;
    logic                  unf_q, unf_d;

    // Stack storage; contents are meaningless until pushed, so no reset
    logic [ADDR_WIDTH-1:0] ras_mem_q [RAS_DEPTH];

    logic [ADDR_WIDTH-1:0] w_adder;
    logic [c_PTR_W-1:0]    w_top_idx;
    logic                  w_push;
    logic                  w_cnt_zero;
    logic                  w_cnt_full;

    assign w_adder    = pc_q + c_INC;
    assign w_cnt_zero = (cnt_q == '0);
    assign w_cnt_full = (cnt_q == c_CNT_FULL);

    // ptr_q names the next free slot; once full it also names the oldest
    // entry, so an overflowing push overwrites exactly that one.
    assign w_top_idx  = ptr_q - c_PTR_ONE;

    always_comb begin
        pc_d   = pc_q;
        cnt_d  = cnt_q;
        ptr_d  = ptr_q;
        ovf_d  = ovf_q;
        unf_d  = unf_q;
        w_push = 1'b0;

        if (stall) begin
            pc_d = pc_q;
        end else if (ret) begin
            if (!w_cnt_zero) begin
                pc_d  = ras_mem_q[w_top_idx];
                ptr_d = w_top_idx;
                cnt_d = cnt_q - c_CNT_ONE;
            end else begin
                pc_d  = w_adder;
                unf_d = 1'b1;
            end
        end else if (call) begin
            w_push = 1'b1;
            pc_d   = branch_target;
            ptr_d  = ptr_q + c_PTR_ONE;
            if (w_cnt_full) begin
                ovf_d = 1'b1;
            end else begin
                cnt_d = cnt_q + c_CNT_ONE;
            end
        end else if (branch_taken) begin
            pc_d = branch_target;
        end else begin
            pc_d = w_adder;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc_q  <= RESET_VEC;
            cnt_q <= '0;
            ptr_q <= '0;
            ovf_q <= 1'b0;
            unf_q <= 1'b0;
        end else begin
            pc_q  <= pc_d;
            cnt_q <= cnt_d;
            ptr_q <= ptr_d;
            ovf_q <= ovf_d;
            unf_q <= unf_d;
        end
    end

    always_ff @(posedge clk) begin
        if (w_push && !rst) begin
            ras_mem_q[ptr_q] <= w_adder;
        end
    end

    assign pc_out        = pc_q;
    assign adder_out     = w_adder;
    assign ras_empty     = w_cnt_zero;
    assign ras_full      = w_cnt_full;
    assign ras_overflow  = ovf_q;
    assign ras_underflow = unf_q;

endmodule

`default_nettype wire

// File: tb/tb_pc_unit.sv
`default_nettype none
// ============================================================================
// Module      : tb_pc_unit
// Description : Directed self-checking bench for pc_unit (default params).
// Revision    : 1.0 - initial release
// ============================================================================

module tb_pc_unit;

    localparam int unsigned AW = 64;

    logic          clk;
    logic          rst;
    logic          stall;
    logic          branch_taken;
    logic [AW-1:0] branch_target;
    logic          call;
    logic          ret;
    logic [AW-1:0] pc_out;
    logic [AW-1:0] adder_out;
    logic          ras_empty;
    logic          ras_full;
    logic          ras_overflow;
    logic          ras_underflow;

    int checks;
    int errors;

    pc_unit #(
        .ADDR_WIDTH (64),
        .INC        (4),
        .RESET_VEC  (64'h0),
        .RAS_DEPTH  (8)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .stall         (stall),
        .branch_taken  (branch_taken),
        .branch_target (branch_target),
        .call          (call),
        .ret           (ret),
        .pc_out        (pc_out),
        .adder_out     (adder_out),
        .ras_empty     (ras_empty),
        .ras_full      (ras_full),
        .ras_overflow  (ras_overflow),
        .ras_underflow (ras_underflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout required completion");
        $fatal(1, "watchdog expired");
    end

    // Advance one edge; outputs are sampled 1 ns after the rising edge
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Load a PC through a plain branch; stack is not touched
    task automatic goto(input logic [AW-1:0] addr);
        branch_taken  = 1'b1;
        branch_target = addr;
        step();
        branch_taken  = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1; stall = 1'b0; branch_taken = 1'b0; call = 1'b0; ret = 1'b0;
        branch_target = '0;
        #10;
        checks++; if (pc_out !== 64'h0) begin errors++; $display("FAIL reset_pc: got %h required %h", pc_out, 64'h0); end
        checks++; if (adder_out !== 64'h4) begin errors++; $display("FAIL reset_adder: got %h required %h", adder_out, 64'h4); end
        checks++; if ({ras_empty, ras_full, ras_overflow, ras_underflow} !== 4'b1000) begin
            errors++; $display("FAIL reset_flags: got %b required %b", {ras_empty, ras_full, ras_overflow, ras_underflow}, 4'b1000);
        end
        rst = 1'b0;
    endtask

    task automatic test_sequential();
        for (int i = 1; i <= 4; i++) begin
            step();
            checks++; if (pc_out !== 64'(4 * i)) begin errors++; $display("FAIL seq_pc[%0d]: got %h required %h", i, pc_out, 64'(4 * i)); end
            checks++; if (adder_out !== 64'(4 * i + 4)) begin errors++; $display("FAIL seq_adder[%0d]: got %h required %h", i, adder_out, 64'(4 * i + 4)); end
        end
        // Asynchronous reset mid-cycle, well before the next edge
        rst = 1'b1;
        #1;
        checks++; if (pc_out !== 64'h0) begin errors++; $display("FAIL async_reset_pc: got %h required %h", pc_out, 64'h0); end
        @(negedge clk);
        rst = 1'b0;
        step();
        checks++; if (pc_out !== 64'h4) begin errors++; $display("FAIL post_reset_pc: got %h required %h", pc_out, 64'h4); end
    endtask

    task automatic test_stall_branch();
        goto(64'h10);
        stall = 1'b1; branch_taken = 1'b1; branch_target = 64'h100;
        for (int i = 0; i < 3; i++) begin
            step();
            checks++; if (pc_out !== 64'h10) begin errors++; $display("FAIL stall_hold[%0d]: got %h required %h", i, pc_out, 64'h10); end
        end
        stall = 1'b0;
        step();
        checks++; if (pc_out !== 64'h100) begin errors++; $display("FAIL branch_load: got %h required %h", pc_out, 64'h100); end
        branch_taken = 1'b0;
        step();
        checks++; if (pc_out !== 64'h104) begin errors++; $display("FAIL branch_seq: got %h required %h", pc_out, 64'h104); end
    endtask

    task automatic test_call_return();
        goto(64'h20);
        call = 1'b1; branch_target = 64'h400;
        step();
        call = 1'b0;
        checks++; if (pc_out !== 64'h400) begin errors++; $display("FAIL call_pc: got %h required %h", pc_out, 64'h400); end
        checks++; if (ras_empty !== 1'b0) begin errors++; $display("FAIL call_not_empty: got %b required %b", ras_empty, 1'b0); end
        step();
        checks++; if (pc_out !== 64'h404) begin errors++; $display("FAIL call_run1: got %h required %h", pc_out, 64'h404); end
        step();
        checks++; if (pc_out !== 64'h408) begin errors++; $display("FAIL call_run2: got %h required %h", pc_out, 64'h408); end
        ret = 1'b1;
        step();
        ret = 1'b0;
        checks++; if (pc_out !== 64'h24) begin errors++; $display("FAIL ret_pc: got %h required %h", pc_out, 64'h24); end
        checks++; if (ras_empty !== 1'b1) begin errors++; $display("FAIL ret_empty: got %b required %b", ras_empty, 1'b1); end
    endtask

    task automatic test_overflow();
        logic [AW-1:0] a_k;
        for (int k = 0; k < 9; k++) begin
            a_k = 64'h1000 + 64'(k * 256);
            goto(a_k);
            call = 1'b1; branch_target = 64'hF000;
            step();
            call = 1'b0;
            if (k == 6) begin
                checks++; if (ras_full !== 1'b0) begin errors++; $display("FAIL ovf_not_full_7: got %b required %b", ras_full, 1'b0); end
            end
            if (k == 7) begin
                checks++; if ({ras_full, ras_overflow} !== 2'b10) begin errors++; $display("FAIL ovf_full_8: got %b required %b", {ras_full, ras_overflow}, 2'b10); end
            end
            if (k == 8) begin
                checks++; if ({ras_full, ras_overflow} !== 2'b11) begin errors++; $display("FAIL ovf_set_9: got %b required %b", {ras_full, ras_overflow}, 2'b11); end
            end
        end
        ret = 1'b1;
        for (int j = 0; j < 8; j++) begin
            a_k = 64'h1000 + 64'((8 - j) * 256) + 64'h4;
            step();
            checks++; if (pc_out !== a_k) begin errors++; $display("FAIL ovf_ret[%0d]: got %h required %h", j, pc_out, a_k); end
        end
        checks++; if ({ras_empty, ras_underflow} !== 2'b10) begin errors++; $display("FAIL ovf_drained: got %b required %b", {ras_empty, ras_underflow}, 2'b10); end
        step();
        ret = 1'b0;
        checks++; if (pc_out !== 64'h1108) begin errors++; $display("FAIL unf_seq_pc: got %h required %h", pc_out, 64'h1108); end
        checks++; if ({ras_empty, ras_underflow, ras_overflow} !== 3'b111) begin
            errors++; $display("FAIL unf_flags: got %b required %b", {ras_empty, ras_underflow, ras_overflow}, 3'b111);
        end
    endtask

    task automatic test_priority();
        goto(64'h7C);
        call = 1'b1; branch_target = 64'h200;
        step();
        call = 1'b0;
        checks++; if (pc_out !== 64'h200) begin errors++; $display("FAIL prio_setup: got %h required %h", pc_out, 64'h200); end
        ret = 1'b1; call = 1'b1; branch_taken = 1'b1; branch_target = 64'h300;
        step();
        ret = 1'b0; call = 1'b0; branch_taken = 1'b0;
        checks++; if (pc_out !== 64'h80) begin errors++; $display("FAIL prio_ret_wins: got %h required %h", pc_out, 64'h80); end
        checks++; if ({ras_empty, ras_full} !== 2'b10) begin errors++; $display("FAIL prio_no_push: got %b required %b", {ras_empty, ras_full}, 2'b10); end
        step();
        checks++; if (pc_out !== 64'h84) begin errors++; $display("FAIL prio_seq: got %h required %h", pc_out, 64'h84); end
    endtask

    task automatic test_back_to_back();
        goto(64'h500);
        call = 1'b1; branch_taken = 1'b1; branch_target = 64'h600;
        step();
        call = 1'b0; branch_taken = 1'b0; ret = 1'b1;
        checks++; if (pc_out !== 64'h600) begin errors++; $display("FAIL b2b_call_branch: got %h required %h", pc_out, 64'h600); end
        step();
        ret = 1'b0;
        checks++; if (pc_out !== 64'h504) begin errors++; $display("FAIL b2b_ret: got %h required %h", pc_out, 64'h504); end
        checks++; if (ras_empty !== 1'b1) begin errors++; $display("FAIL b2b_empty: got %b required %b", ras_empty, 1'b1); end
    endtask

    task automatic test_wrap();
        goto(64'hFFFF_FFFF_FFFF_FFFF);
        checks++; if (pc_out !== 64'hFFFF_FFFF_FFFF_FFFF) begin errors++; $display("FAIL wrap_unaligned_pc: got %h required %h", pc_out, 64'hFFFF_FFFF_FFFF_FFFF); end
        checks++; if (adder_out !== 64'h3) begin errors++; $display("FAIL wrap_adder_ones: got %h required %h", adder_out, 64'h3); end
        goto(64'hFFFF_FFFF_FFFF_FFFC);
        checks++; if (adder_out !== 64'h0) begin errors++; $display("FAIL wrap_adder: got %h required %h", adder_out, 64'h0); end
        step();
        checks++; if (pc_out !== 64'h0) begin errors++; $display("FAIL wrap_pc: got %h required %h", pc_out, 64'h0); end
    endtask

    task automatic test_flags_clear();
        rst = 1'b1;
        #1;
        checks++; if ({ras_empty, ras_full, ras_overflow, ras_underflow} !== 4'b1000) begin
            errors++; $display("FAIL sticky_clear: got %b required %b", {ras_empty, ras_full, ras_overflow, ras_underflow}, 4'b1000);
        end
        @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        checks = 0;
        errors = 0;
        test_reset();
        test_sequential();
        test_stall_branch();
        test_call_return();
        test_overflow();
        test_priority();
        test_back_to_back();
        test_wrap();
        test_flags_clear();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/pc_unit.md
Name: pc_unit

Overview:
- Parametrised program-counter stage for the Olivia core; next generation of the fixed 64-bit PC plus +4 adder.
- Adds configurable width, increment and reset vector, a stall hold, taken-branch load, and call/return through an internal return-address stack (RAS).
- Sits at the head of the fetch path.
- Drives `pc_out` to instruction memory and `adder_out` (the sequential next PC) to downstream logic.

Parameters:
- ADDR_WIDTH, 64, width of PC, targets and stack entries.
- INC, 4, sequential increment added to PC.
- RESET_VEC, 0, PC value on reset.
- RAS_DEPTH, 8, number of return-address stack entries (power of 2, >=2).

Ports:
- clk  in  1  system clock, rising-edge.
- rst  in  1  asynchronous, active-high reset.
- stall  in  1  hold PC and stack; all other requests ignored this cycle.
- branch_taken  in  1  load branch_target into PC.
- branch_target  in  ADDR_WIDTH  target for branch and call.
- call  in  1  push adder_out onto RAS, load branch_target.
- ret  in  1  pop RAS top into PC.
- pc_out  out  ADDR_WIDTH  current PC (registered).
- adder_out  out  ADDR_WIDTH  pc_out + INC (combinational, modulo 2^ADDR_WIDTH).
- ras_empty  out  1  stack holds 0 entries.
- ras_full  out  1  stack holds RAS_DEPTH entries.
- ras_overflow  out  1  sticky: a call occurred while full.
- ras_underflow  out  1  sticky: a ret occurred while empty.

Behaviour:
- One clock; reset is asynchronous and active-high.
- Reset state, immediate on rst assertion, no clock required:
  - pc_out = RESET_VEC, count = 0, pointer = 0.
  - ras_empty = 1, ras_full = 0, ras_overflow = 0, ras_underflow = 0.
  - Stack contents are don't-care.
- Reset mid-operation discards any in-flight request; the first update after rst deasserts occurs on the next rising edge.
- Per-edge priority (first match wins): stall > ret > call > branch_taken > sequential.
  - stall=1: PC, stack, count and flags unchanged.
  - ret, count>0: pc_out <= top entry; count decrements; entry consumed.
  - ret, count==0: pc_out <= adder_out (sequential); ras_underflow <= 1; count stays 0.
  - call, count<RAS_DEPTH: push adder_out; count increments; pc_out <= branch_target.
  - call, count==RAS_DEPTH: circular overwrite of the oldest entry with adder_out; count stays RAS_DEPTH; ras_overflow <= 1; pc_out <= branch_target.
  - branch_taken: pc_out <= branch_target; stack untouched.
  - Otherwise: pc_out <= adder_out.
- call and branch_taken together behave as call (identical PC result, plus the push).
- ret together with call or branch: ret wins; no push occurs.
- Latency: the new PC is visible on pc_out one cycle after the request edge.
  - adder_out follows pc_out combinationally in the same cycle.
- Arithmetic:
  - adder_out wraps modulo 2^ADDR_WIDTH (e.g. all-ones + 4 = 3 at 64 bits).
  - branch_target is loaded unmodified; no alignment forcing.
- Stack is implemented as a circular buffer with a top pointer and a separate occupancy count.
  - After an overflow wrap, the most recent RAS_DEPTH return addresses remain retrievable in LIFO order.
- ras_empty and ras_full are registered-state decodes of count; they update in the cycle after the edge that changes count.
- Sticky flags clear only on rst.

Test Plan:
- Reset/sequential:
  - Stimulus: rst high 10 ns, release; default params, no requests.
  - Required: pc_out 0, 4, 8, … one step per edge; adder_out = pc_out+4 every cycle; rst reasserted mid-run forces pc_out = 0 asynchronously, before the next edge.
- Stall and branch:
  - Stimulus: at pc=0x10 assert stall for 3 cycles with branch_taken=1, target 0x100; then drop stall.
  - Required: pc holds 0x10 for 3 cycles, then 0x100 next cycle, then 0x104.
- Call/return:
  - Stimulus: at pc=0x20, call target 0x400; run 2 cycles; ret.
  - Required: pc = 0x400, 0x404, 0x408; after ret, pc = 0x24; ras_empty returns to 1.
- Overflow:
  - Stimulus: RAS_DEPTH=8; 9 nested calls from pcs A0..A8; then 9 rets.
  - Required: ras_full after call 8; ras_overflow=1 after call 9.
  - Required: first 8 rets yield A8+4 … A1+4 in that order.
  - Required: 9th ret finds the stack empty, so pc goes sequential and ras_underflow=1.
- Priority:
  - Stimulus: ret+call+branch_taken in the same cycle with 1 stack entry 0x80.
  - Required: pc = 0x80; count 0; no push.
- Wrap:
  - Stimulus: branch to 0xFFFF_FFFF_FFFF_FFFC.
  - Required: adder_out = 0; next pc_out = 0.
